// File: rtl/rr_arbiter_16.sv
// Round-robin arbiter for 16 requesters with a registered one-hot grant and index.
// Optional forced release after HOLD_MAX cycles when ARB_TIMEOUT_EN is defined.
module rr_arbiter_16 #(
  parameter int FIXED_PRI = 0,
  parameter int HOLD_MAX  = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  input  logic [15:0] req,
  input  logic        done,
  output logic [15:0] gnt,
  output logic [3:0]  gnt_id,
  output logic        gnt_valid,
  output logic        timeout
);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t     state;
  logic [3:0] ptr;
  logic [3:0] start;
  logic [3:0] idx;
  logic [3:0] win_id;
  logic       release_now;
  logic       hold_expired;

  if (HOLD_MAX < 1 || HOLD_MAX > 255) begin : g_bad_hold_max
    $error("rr_arbiter_16: HOLD_MAX must be in 1..255");
  end

  // Scan downward so the set bit closest above start is the last one written.
  // NOTE: every always_comb output gets a default first, so no path leaves it unassigned and no latch appears.
  always_comb begin
    start  = (FIXED_PRI != 0) ? 4'd0 : ptr;
    win_id = start;
    idx    = start;
    for (int i = 15; i >= 0; i--) begin
      idx = start + 4'(i);
      if (req[idx]) win_id = idx;
    end
  end

  assign release_now = done | ~req[gnt_id];

`ifdef ARB_TIMEOUT_EN
  localparam logic [7:0] HOLD_LAST = 8'(HOLD_MAX - 1);

  logic [7:0] hold_cnt;

  assign hold_expired = (hold_cnt == HOLD_LAST);
`else
  assign hold_expired = 1'b0;
  assign timeout      = 1'b0;
`endif

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      gnt       <= '0;
      gnt_id    <= '0;
      gnt_valid <= 1'b0;
      ptr       <= '0;
`ifdef ARB_TIMEOUT_EN
      hold_cnt  <= '0;
      timeout   <= 1'b0;
`endif
    end else begin
`ifdef ARB_TIMEOUT_EN
      timeout <= 1'b0;
`endif
      case (state)
        IDLE: begin
          if (enable && |req) begin
            state     <= GRANT;
            gnt       <= 16'b1 << win_id;
            gnt_id    <= win_id;
            gnt_valid <= 1'b1;
`ifdef ARB_TIMEOUT_EN
            hold_cnt  <= '0;
`endif
          end
        end
        GRANT: begin
          // A normal release on the expiry edge wins, so timeout only flags a forced one.
          if (release_now || hold_expired) begin
            state     <= IDLE;
            gnt       <= '0;
            gnt_id    <= '0;
            gnt_valid <= 1'b0;
            ptr       <= gnt_id + 4'd1;
`ifdef ARB_TIMEOUT_EN
            timeout   <= ~release_now;
`endif
          end
`ifdef ARB_TIMEOUT_EN
          else begin
            hold_cnt <= hold_cnt + 8'd1;
          end
`endif
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rr_arbiter_16.sv
// Directed bench for rr_arbiter_16: a round-robin instance and a fixed-priority
// instance with HOLD_MAX = 4; expected grant indices go through per-instance queues.
module tb_rr_arbiter_16;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        r_reset, r_enable, r_done;
  logic [15:0] r_req, r_gnt;
  logic [3:0]  r_gnt_id;
  logic        r_gnt_valid, r_timeout;

  logic        f_reset, f_enable, f_done;
  logic [15:0] f_req, f_gnt;
  logic [3:0]  f_gnt_id;
  logic        f_gnt_valid, f_timeout;

  rr_arbiter_16 #(.FIXED_PRI(0), .HOLD_MAX(255)) u_rr (
    .clk(clk), .reset(r_reset), .enable(r_enable), .req(r_req), .done(r_done),
    .gnt(r_gnt), .gnt_id(r_gnt_id), .gnt_valid(r_gnt_valid), .timeout(r_timeout)
  );

  rr_arbiter_16 #(.FIXED_PRI(1), .HOLD_MAX(4)) u_fx (
    .clk(clk), .reset(f_reset), .enable(f_enable), .req(f_req), .done(f_done),
    .gnt(f_gnt), .gnt_id(f_gnt_id), .gnt_valid(f_gnt_valid), .timeout(f_timeout)
  );

  logic [3:0] rr_q[$];
  logic [3:0] fx_q[$];
  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Waits (bounded) for the selected instance to grant, then pops the expected index.
  task automatic expect_grant(input string tag, input bit fx, input int lat);
    int n = 0;
    logic [3:0] exp_id;
    logic v;
    do begin
      tick();
      n++;
      v = fx ? f_gnt_valid : r_gnt_valid;
    end while (v !== 1'b1 && n < 20);
    check({tag, " latency"}, n, lat);
    if (fx ? (fx_q.size() == 0) : (rr_q.size() == 0)) begin
      check({tag, " queue"}, 0, 1);
    end else begin
      exp_id = fx ? fx_q.pop_front() : rr_q.pop_front();
      check({tag, " gnt_id"}, fx ? f_gnt_id : r_gnt_id, exp_id);
      check({tag, " gnt"}, fx ? f_gnt : r_gnt, 16'b1 << exp_id);
    end
  endtask

  initial begin
    int cnt;
    r_reset = 1'b1; r_enable = 1'b1; r_req = 16'hFFFF; r_done = 1'b0;
    f_reset = 1'b1; f_enable = 1'b0; f_req = 16'h0000; f_done = 1'b0;

    // Reset with every requester asserted.
    tick(); tick();
    check("reset gnt", r_gnt, 16'h0000);
    check("reset gnt_valid", r_gnt_valid, 1'b0);
    check("reset timeout", r_timeout, 1'b0);
    check("reset fx gnt_valid", f_gnt_valid, 1'b0);
    r_reset = 1'b0;
    rr_q.push_back(4'd0);
    expect_grant("first grant", 1'b0, 1);
    r_done = 1'b1;
    tick();
    r_done = 1'b0;
    check("first release", r_gnt_valid, 1'b0);

    // Rotation from a fresh pointer.
    r_reset = 1'b1; r_req = 16'h8421;
    tick();
    r_reset = 1'b0;
    foreach (rr_q[i]) rr_q.delete(i);
    rr_q.push_back(4'd0); rr_q.push_back(4'd5); rr_q.push_back(4'd10);
    rr_q.push_back(4'd15); rr_q.push_back(4'd0);
    for (int k = 0; k < 5; k++) begin
      expect_grant("rotation", 1'b0, 1);
      if (k < 4) begin
        r_done = 1'b1;
        tick();
        r_done = 1'b0;
        check("rotation gap", r_gnt_valid, 1'b0);
      end
    end

    // Reset mid-grant returns pointer to zero.
    r_reset = 1'b1;
    tick();
    check("mid reset gnt", r_gnt, 16'h0000);
    check("mid reset gnt_valid", r_gnt_valid, 1'b0);
    r_reset = 1'b0;
    rr_q.push_back(4'd0);
    expect_grant("post reset", 1'b0, 1);
    r_done = 1'b1;
    tick();
    r_done = 1'b0;

    // Wrap and withdraw: bring ptr to 15 via a grant to 14.
    r_req = 16'h4000;
    rr_q.push_back(4'd14);
    expect_grant("to 14", 1'b0, 1);
    r_done = 1'b1; r_req = 16'h0006;
    tick();
    r_done = 1'b0;
    rr_q.push_back(4'd1);
    expect_grant("wrap", 1'b0, 1);
    r_req = 16'h0004;
    tick();
    check("withdraw gnt", r_gnt, 16'h0000);
    rr_q.push_back(4'd2);
    expect_grant("after withdraw", 1'b0, 1);
    r_done = 1'b1;
    tick();
    r_done = 1'b0;

    // Enable gating.
    r_enable = 1'b0; r_req = 16'h0010;
    cnt = 0;
    for (int k = 0; k < 10; k++) begin
      tick();
      if (r_gnt_valid !== 1'b0) cnt++;
    end
    check("enable low no grant", cnt, 0);
    r_enable = 1'b1;
    rr_q.push_back(4'd4);
    expect_grant("enable rise", 1'b0, 1);
    r_enable = 1'b0; r_req = 16'h0013;
    cnt = 0;
    for (int k = 0; k < 5; k++) begin
      tick();
      if (r_gnt === 16'h0010) cnt++;
    end
    check("hold without enable", cnt, 5);
    r_done = 1'b1;
    tick();
    r_done = 1'b0; r_req = 16'h0000;
    check("enable test release", r_gnt_valid, 1'b0);

    // Fixed priority: index 10 every time while it stays requested.
    f_reset = 1'b0; f_enable = 1'b1; f_req = 16'h0C00;
    for (int k = 0; k < 3; k++) begin
      fx_q.push_back(4'd10);
      expect_grant("fixed pri", 1'b1, 1);
      f_done = 1'b1;
      tick();
      f_done = 1'b0;
      check("fixed pri gap", f_gnt_valid, 1'b0);
    end

    // Hold limit on the HOLD_MAX = 4 instance.
    f_req = 16'h0001;
    fx_q.push_back(4'd0);
    expect_grant("hold grant", 1'b1, 1);
`ifdef ARB_TIMEOUT_EN
    cnt = 1;
    for (int k = 0; k < 3; k++) begin
      tick();
      if (f_gnt_valid === 1'b1 && f_timeout === 1'b0) cnt++;
    end
    check("hold cycles", cnt, 4);
    tick();
    check("timeout pulse", f_timeout, 1'b1);
    check("timeout gnt", f_gnt, 16'h0000);
    fx_q.push_back(4'd0);
    expect_grant("regrant", 1'b1, 1);
    check("timeout one cycle", f_timeout, 1'b0);
    tick(); tick(); tick();
    check("fourth cycle valid", f_gnt_valid, 1'b1);
    f_done = 1'b1;
    tick();
    f_done = 1'b0;
    check("done beats timeout", f_timeout, 1'b0);
    check("done release", f_gnt_valid, 1'b0);
`else
    cnt = 0;
    for (int k = 0; k < 8; k++) begin
      tick();
      if (f_gnt_valid === 1'b1 && f_timeout === 1'b0) cnt++;
    end
    check("no timeout hold", cnt, 8);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/rr_arbiter_16.md
# rr_arbiter_16

Round-robin arbiter that shares one downstream resource among 16 requesters. It converts a 16-bit request vector into a registered one-hot grant plus a 4-bit binary grant index. A grant is held until the owner releases it. The block sits in front of any shared datapath that is currently fed by a priority encoder, and replaces fixed priority with rotating fairness.

## Interface
- `FIXED_PRI`, default 0: 1 = fixed priority, lowest index wins, and the pointer is ignored; 0 = round-robin.
- `HOLD_MAX`, default 255: maximum grant hold in cycles, range 1..255; used only with `ARB_TIMEOUT_EN`.
- `clk`  input  1  clock; all logic on the rising edge.
- `reset`  input  1  synchronous, active-high reset.
- `enable`  input  1  permits new grants; does not preempt an existing grant.
- `req`  input  16  request vector; bit n = requester n.
- `done`  input  1  owner release strobe; sampled only in GRANT.
- `gnt`  output  16  one-hot grant, registered.
- `gnt_id`  output  4  binary index of the granted requester, registered.
- `gnt_valid`  output  1  high while a grant is held.
- `timeout`  output  1  one-cycle pulse on forced release.

## Operation
- States:
  - IDLE: no grant.
  - GRANT: one requester owns the resource.
- Reset values: state = IDLE, `gnt` = 16'h0000, `gnt_id` = 0, `gnt_valid` = 0, `timeout` = 0, pointer `ptr` = 0, hold counter = 0.
- IDLE to GRANT: taken when `enable` && |`req`.
  - Winner (round-robin): the first set bit of `req` searching upward from `ptr`, wrapping 15 to 0.
  - Winner (`FIXED_PRI` = 1): the lowest set bit.
  - `gnt` and `gnt_id` load the winner. `gnt_valid` goes to 1. The hold counter clears.
- In IDLE with `enable` = 0 or `req` = 0: outputs stay zero.
- GRANT to IDLE: taken on `done` = 1, or when `req[gnt_id]` = 0 (requester withdrew).
  - `gnt`, `gnt_id` and `gnt_valid` clear.
  - `ptr` becomes (`gnt_id` + 1) mod 16, with wrap-around from 15 to 0.
- In GRANT, `enable` = 0 has no effect. Grants are never preempted except by timeout.
- In GRANT, changes to other `req` bits are ignored.
- Invariants:
  - `gnt` = 1 << `gnt_id` whenever `gnt_valid` = 1.
  - `gnt` = 0 whenever `gnt_valid` = 0.

## Timing
- Grant latency: `req` sampled high at edge N gives `gnt_valid` = 1 after edge N. The minimum latency is one cycle.
- Release: `done` sampled at edge M gives `gnt` = 0 after edge M.
- Turnaround: there is always at least one IDLE cycle (`gnt_valid` = 0) between consecutive grants, even to different requesters.
- Back-to-back grants: the same requester is granted again only after all other pending requesters have been served. This holds in round-robin mode only.
- `done` while in IDLE is ignored.
- `done` and the `req[gnt_id]` drop arriving together count as a single release.
- Reset mid-grant: the next edge returns every output and `ptr` to their reset values regardless of `req` and `done`.

## Configuration
- Macro: `ARB_TIMEOUT_EN`.
- Defined:
  - An 8-bit hold counter increments each cycle in GRANT.
  - When the counter equals `HOLD_MAX` - 1 and no release is present, the next edge forces GRANT to IDLE.
  - That edge pulses `timeout` = 1 for one cycle and advances `ptr` exactly as a normal release does.
  - A grant therefore lasts at most `HOLD_MAX` cycles.
  - A normal release on the same edge takes precedence: `timeout` stays 0.
- Undefined:
  - No counter is present.
  - `timeout` is tied to 0.
  - Grants last until release.
  - `HOLD_MAX` is unused.

## Test plan
- Reset/idle: assert `reset` with `req` = 16'hFFFF and `done` = 0. Required: `gnt` = 0, `gnt_valid` = 0 and `timeout` = 0 during reset. After release of reset, the first grant is `gnt_id` = 0.
- Rotation: hold `req` = 16'h8421 and pulse `done` one cycle after each grant. Required: `gnt_id` sequence 0, 5, 10, 15, 0, with exactly one `gnt_valid` = 0 cycle between grants.
- Wrap and withdraw:
  - Setup: `ptr` = 15, `req` = 16'h0006.
  - Required: grant goes to 1.
  - Then drop `req[1]`. Required: `gnt` = 0 on the next cycle, then a grant to 2.
- Enable gating:
  - With `enable` = 0 and `req` = 16'h0010: no grant for 10 cycles.
  - Raise `enable`: `gnt` = 16'h0010 one cycle later.
  - Drop `enable` during GRANT: the grant is held until `done`.
- `FIXED_PRI` = 1: `req` = 16'h0C00 with repeated `done`. Required: `gnt_id` = 10 every time while `req[10]` stays high.
- Timeout (`ARB_TIMEOUT_EN`, `HOLD_MAX` = 4):
  - With `req` = 16'h0001 held and no `done`: `gnt_valid` is high for exactly 4 cycles, then `timeout` pulses for 1 cycle with `gnt` = 0.
  - Next, `done` on the 4th cycle: `timeout` = 0.
